// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Memory-side controller for the byte-addressed baseCache family.
//   A read miss fetches the whole block one byte per memory handshake and
//   writes it into the cache in a single fill cycle. CPU writes are forwarded
//   to memory (write-through, no write-allocate). The CPU is stalled until
//   each access retires in DONE.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req/wr/addr/wdata    CPU access, held stable while stall=1
//   hit                  cache hit for addr, same cycle
//   stall                CPU must hold its current access
//   fill_wr/addr/data    one-cycle block write into the cache
//   mem_req/we/addr/wdata, mem_ack, mem_rdata   byte-wide memory handshake
module cache_refill_ctrl #(
    parameter int BLOCK_SIZE  = 4,
    parameter int BLOCK_WIDTH = BLOCK_SIZE * 8,
    parameter int OFF_W       = $clog2(BLOCK_SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   wr,
    input  logic [31:0]            addr,
    input  logic [7:0]             wdata,
    input  logic                   hit,
    output logic                   stall,
    output logic                   fill_wr,
    output logic [31:0]            fill_addr,
    output logic [BLOCK_WIDTH-1:0] fill_data,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_rdata
);
    // A 1-byte block still needs a 1-bit beat counter to keep widths legal.
    localparam int                BEAT_W    = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [31:0]       BLK_MASK  = ~(32'(BLOCK_SIZE) - 32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_SIZE - 1);

    typedef enum logic [2:0] {IDLE, RD_BEAT, FILL, WR_MEM, DONE} state_t;

    state_t                     state;
    logic [31:0]                base;
    logic [31:0]                wr_addr;
    logic [7:0]                 wr_byte;
    logic [BEAT_W-1:0]          beat;
    logic [BLOCK_SIZE-1:0][7:0] buffer;
    logic                       start;
    logic                       beat_ack;

    // rst gates start so stall drops the moment reset asserts.
    assign start    = ~rst & (state == IDLE) & req & (wr | ~hit);
    assign beat_ack = (state == RD_BEAT) & mem_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            beat    <= '0;
            wr_addr <= '0;
            wr_byte <= '0;
            buffer  <= '0;
        end else begin
            // Lane k captures the byte returned for beat k.
            for (int k = 0; k < BLOCK_SIZE; k++)
                if (beat_ack && beat == BEAT_W'(k))
                    buffer[k] <= mem_rdata;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (wr) begin
                            wr_addr <= addr;
                            wr_byte <= wdata;
                            state   <= WR_MEM;
                        end else begin
                            base  <= addr & BLK_MASK;
                            beat  <= '0;
                            state <= RD_BEAT;
                        end
                    end
                end
                RD_BEAT: begin
                    if (mem_ack) begin
                        if (beat == LAST_BEAT) state <= FILL;
                        else                   beat  <= beat + BEAT_W'(1);
                    end
                end
                FILL:    state <= DONE;
                WR_MEM:  if (mem_ack) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state, so they fall together
    // with an asynchronous reset; address/data read 0 outside their states.
    always_comb begin
        stall     = start | (state == RD_BEAT) | (state == FILL) | (state == WR_MEM);
        mem_req   = (state == RD_BEAT) | (state == WR_MEM);
        mem_we    = (state == WR_MEM);
        fill_wr   = (state == FILL);
        mem_addr  = '0;
        mem_wdata = '0;
        fill_addr = '0;
        fill_data = '0;
        case (state)
            // base is block aligned, so OR-ing the beat never carries.
            RD_BEAT: mem_addr = base | 32'(beat);
            WR_MEM: begin
                mem_addr  = wr_addr;
                mem_wdata = wr_byte;
            end
            FILL: begin
                fill_addr = base;
                fill_data = buffer;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: three builds (BLOCK_SIZE 1, 4, 8) share the
// CPU/memory stimulus; only the selected build sees req and mem_ack.
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, wr, hit, mem_ack;
    logic [31:0] addr;
    logic [7:0]  wdata, mem_rdata;
    logic [1:0]  sel;                 // 0: B=1, 1: B=4, 2: B=8

    logic [2:0]  req_v, ack_v, stall_v, fw_v, mreq_v, mwe_v;
    logic [31:0] fa_v [3];
    logic [31:0] ma_v [3];
    logic [7:0]  mwd_v [3];
    logic [7:0]  fd1;
    logic [31:0] fd4;
    logic [63:0] fd8;

    logic        stall_s, fw_s, mreq_s, mwe_s;
    logic [31:0] fa_s, ma_s;
    logic [7:0]  mwd_s;
    logic [63:0] fd_s;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            req_v[i] = req && (sel == 2'(i));
            ack_v[i] = mem_ack && (sel == 2'(i));
        end
    end

    cache_refill_ctrl #(.BLOCK_SIZE(1)) u_b1 (
        .clk(clk), .rst(rst), .req(req_v[0]), .wr(wr), .addr(addr), .wdata(wdata),
        .hit(hit), .stall(stall_v[0]), .fill_wr(fw_v[0]), .fill_addr(fa_v[0]),
        .fill_data(fd1), .mem_req(mreq_v[0]), .mem_we(mwe_v[0]), .mem_addr(ma_v[0]),
        .mem_wdata(mwd_v[0]), .mem_ack(ack_v[0]), .mem_rdata(mem_rdata));
    cache_refill_ctrl #(.BLOCK_SIZE(4)) u_b4 (
        .clk(clk), .rst(rst), .req(req_v[1]), .wr(wr), .addr(addr), .wdata(wdata),
        .hit(hit), .stall(stall_v[1]), .fill_wr(fw_v[1]), .fill_addr(fa_v[1]),
        .fill_data(fd4), .mem_req(mreq_v[1]), .mem_we(mwe_v[1]), .mem_addr(ma_v[1]),
        .mem_wdata(mwd_v[1]), .mem_ack(ack_v[1]), .mem_rdata(mem_rdata));
    cache_refill_ctrl #(.BLOCK_SIZE(8)) u_b8 (
        .clk(clk), .rst(rst), .req(req_v[2]), .wr(wr), .addr(addr), .wdata(wdata),
        .hit(hit), .stall(stall_v[2]), .fill_wr(fw_v[2]), .fill_addr(fa_v[2]),
        .fill_data(fd8), .mem_req(mreq_v[2]), .mem_we(mwe_v[2]), .mem_addr(ma_v[2]),
        .mem_wdata(mwd_v[2]), .mem_ack(ack_v[2]), .mem_rdata(mem_rdata));

    always_comb begin
        case (sel)
            2'd0: begin
                stall_s = stall_v[0]; fw_s = fw_v[0]; mreq_s = mreq_v[0]; mwe_s = mwe_v[0];
                fa_s = fa_v[0]; ma_s = ma_v[0]; mwd_s = mwd_v[0]; fd_s = {56'b0, fd1};
            end
            2'd1: begin
                stall_s = stall_v[1]; fw_s = fw_v[1]; mreq_s = mreq_v[1]; mwe_s = mwe_v[1];
                fa_s = fa_v[1]; ma_s = ma_v[1]; mwd_s = mwd_v[1]; fd_s = {32'b0, fd4};
            end
            default: begin
                stall_s = stall_v[2]; fw_s = fw_v[2]; mreq_s = mreq_v[2]; mwe_s = mwe_v[2];
                fa_s = fa_v[2]; ma_s = ma_v[2]; mwd_s = mwd_v[2]; fd_s = fd8;
            end
        endcase
    end

    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory contents: byte at address a.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] + 8'h6C;
    endfunction

    function automatic int bsz(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 4 : 8;
    endfunction

    // Observations of one access.
    int          o_stall, o_fills, o_gap, o_unstable;
    bit          o_done;
    logic [31:0] o_faddr;
    logic [63:0] o_fdata;
    logic [31:0] o_baddr[$];
    logic [7:0]  o_bwd[$];
    logic        o_bwe[$];

    // Drive one CPU access and act as memory with `waits` wait cycles per
    // handshake. Inputs change just after the falling edge.
    task automatic do_access(input logic [1:0] s, input logic w, input logic [31:0] a,
                             input logic [7:0] d, input logic h, input int waits);
        int wcnt = 0;
        int first_req = -1;
        int last_req = 0;
        int req_cyc = 0;
        bit prev_wait = 0;
        logic [31:0] prev_addr = '0;
        @(negedge clk);
        sel = s; req = 1'b1; wr = w; addr = a; wdata = d; hit = h; mem_ack = 1'b0;
        o_stall = 0; o_fills = 0; o_unstable = 0; o_done = 0;
        o_faddr = '0; o_fdata = '0;
        o_baddr.delete(); o_bwd.delete(); o_bwe.delete();
        for (int c = 0; c < 300; c++) begin
            #1;
            if (stall_s) o_stall++;
            if (fw_s) begin
                o_fills++; o_faddr = fa_s; o_fdata = fd_s;
            end
            mem_ack = 1'b0;
            if (mreq_s) begin
                if (first_req < 0) first_req = c;
                last_req = c;
                req_cyc++;
                if (prev_wait && ma_s != prev_addr) o_unstable++;
                if (wcnt == waits) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_byte(ma_s);
                    o_baddr.push_back(ma_s); o_bwe.push_back(mwe_s); o_bwd.push_back(mwd_s);
                    wcnt = 0; prev_wait = 0;
                end else begin
                    mem_rdata = 8'($urandom);
                    wcnt++; prev_wait = 1;
                end
                prev_addr = ma_s;
            end else begin
                prev_wait = 0;
            end
            if (!stall_s) begin
                o_done = 1;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        o_gap = (first_req < 0) ? 0 : (last_req - first_req + 1 - req_cyc);
        req = 1'b0; wr = 1'b0; hit = 1'b0; mem_ack = 1'b0;
        chk("retired", 64'(o_done), 64'd1);
    endtask

    // Reference model: expectations from the access rules, compared to the
    // observations of the last access.
    task automatic model_check(input logic [1:0] s, input logic w, input logic [31:0] a,
                               input logic [7:0] d, input logic h, input int waits);
        int          b = bsz(s);
        logic [31:0] base = a - (a % 32'(b));
        int          e_stall, e_fills, e_beats;
        logic [63:0] e_data = '0;
        if (!w && h) begin
            e_stall = 0; e_fills = 0; e_beats = 0;
        end else if (w) begin
            e_stall = 2 + waits; e_fills = 0; e_beats = 1;
        end else begin
            e_stall = 2 + b * (waits + 1); e_fills = 1; e_beats = b;
            for (int i = 0; i < b; i++)
                e_data = e_data | (64'(mem_byte(base + 32'(i))) << (8 * i));
        end
        chk("m_stall", 64'(o_stall), 64'(e_stall));
        chk("m_fills", 64'(o_fills), 64'(e_fills));
        chk("m_beats", 64'(o_baddr.size()), 64'(e_beats));
        if (e_fills > 0) begin
            chk("m_faddr", 64'(o_faddr), 64'(base));
            chk("m_fdata", o_fdata, e_data);
        end
        for (int i = 0; i < e_beats && i < o_baddr.size(); i++) begin
            chk("m_baddr", 64'(o_baddr[i]), w ? 64'(a) : 64'(base + 32'(i)));
            chk("m_bwe", 64'(o_bwe[i]), 64'(w));
            if (w) chk("m_bwdata", 64'(o_bwd[i]), 64'(d));
        end
        chk("m_gap", 64'(o_gap), 64'd0);
        chk("m_stable", 64'(o_unstable), 64'd0);
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  s;
        logic        w;
        logic [31:0] a;
        logic [7:0]  d;
        logic        h;
        int          waits;
        int          e_stall;
        int          e_fills;
        logic [31:0] e_faddr;
        logic [63:0] e_fdata;
        int          e_beats;
        logic [31:0] e_first;
        logic [31:0] e_last;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"rd_miss_b4",    2'd1, 1'b0, 32'h1236, 8'h00, 1'b0, 0,  6, 1, 32'h1234, 64'hA3A2A1A0, 4, 32'h1234, 32'h1237};
        tbl[1] = '{"rd_miss_b4_w2", 2'd1, 1'b0, 32'h1236, 8'h00, 1'b0, 2, 14, 1, 32'h1234, 64'hA3A2A1A0, 4, 32'h1234, 32'h1237};
        tbl[2] = '{"wr_hit",        2'd1, 1'b1, 32'h0040, 8'h5C, 1'b1, 0,  2, 0, 32'h0,    64'h0,        1, 32'h0040, 32'h0040};
        tbl[3] = '{"wr_miss",       2'd1, 1'b1, 32'h0040, 8'h5C, 1'b0, 0,  2, 0, 32'h0,    64'h0,        1, 32'h0040, 32'h0040};
        tbl[4] = '{"rd_hit",        2'd1, 1'b0, 32'h1236, 8'h00, 1'b1, 0,  0, 0, 32'h0,    64'h0,        0, 32'h0,    32'h0};
        tbl[5] = '{"b1_miss",       2'd0, 1'b0, 32'h0007, 8'h00, 1'b0, 0,  3, 1, 32'h0007, 64'h73,       1, 32'h0007, 32'h0007};
        tbl[6] = '{"b8_top",        2'd2, 1'b0, 32'hFFFF_FFFB, 8'h00, 1'b0, 0, 10, 1, 32'hFFFF_FFF8,
                   64'h6B6A696867666564, 8, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        tbl[7] = '{"b8_top_w1",     2'd2, 1'b0, 32'hFFFF_FFFB, 8'h00, 1'b0, 1, 18, 1, 32'hFFFF_FFF8,
                   64'h6B6A696867666564, 8, 32'hFFFF_FFF8, 32'hFFFF_FFFF};

        // Reset asserted with a pending read miss: everything forced low.
        rst = 1'b1; sel = 2'd1; req = 1'b1; wr = 1'b0; hit = 1'b0;
        addr = 32'h1236; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_stall", 64'(stall_s), 64'd0);
        chk("rst_ctrl", 64'({fw_s, mreq_s, mwe_s}), 64'd0);
        repeat (2) @(negedge clk);
        req = 1'b0;
        rst = 1'b0;
        #1;
        chk("idle_ctrl", 64'({stall_s, fw_s, mreq_s, mwe_s}), 64'd0);
        chk("idle_data", 64'(ma_s) | 64'(fa_s) | 64'(mwd_s) | fd_s, 64'd0);

        // Spurious acks while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            #1;
            chk("spur_ack", 64'({stall_s, mreq_s, fw_s}), 64'd0);
        end
        mem_ack = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            do_access(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].h, tbl[i].waits);
            chk({tbl[i].nm, "_stall"}, 64'(o_stall), 64'(tbl[i].e_stall));
            chk({tbl[i].nm, "_fills"}, 64'(o_fills), 64'(tbl[i].e_fills));
            chk({tbl[i].nm, "_beats"}, 64'(o_baddr.size()), 64'(tbl[i].e_beats));
            if (tbl[i].e_fills > 0) begin
                chk({tbl[i].nm, "_faddr"}, 64'(o_faddr), 64'(tbl[i].e_faddr));
                chk({tbl[i].nm, "_fdata"}, o_fdata, tbl[i].e_fdata);
            end
            if (tbl[i].e_beats > 0 && o_baddr.size() > 0) begin
                chk({tbl[i].nm, "_first"}, 64'(o_baddr[0]), 64'(tbl[i].e_first));
                chk({tbl[i].nm, "_last"}, 64'(o_baddr[o_baddr.size()-1]), 64'(tbl[i].e_last));
                chk({tbl[i].nm, "_we"}, 64'(o_bwe[0]), 64'(tbl[i].w));
                if (tbl[i].w) chk({tbl[i].nm, "_wdata"}, 64'(o_bwd[0]), 64'(tbl[i].d));
            end
            chk({tbl[i].nm, "_gap"}, 64'(o_gap), 64'd0);
            chk({tbl[i].nm, "_stable"}, 64'(o_unstable), 64'd0);
        end

        // Reset after beat 2 of 4: no fill, and the refetch starts at offset 0.
        begin
            int acks = 0;
            int fills = 0;
            @(negedge clk);
            sel = 2'd1; req = 1'b1; wr = 1'b0; hit = 1'b0; addr = 32'h1236;
            for (int c = 0; c < 20 && acks < 2; c++) begin
                #1;
                if (fw_s) fills++;
                mem_ack = mreq_s;
                if (mreq_s) mem_rdata = 8'hEE;
                @(posedge clk);
                if (mem_ack) acks++;
                @(negedge clk);
            end
            chk("mid_acks", 64'(acks), 64'd2);
            mem_ack = 1'b0;
            rst = 1'b1;
            #1;
            chk("mid_rst_stall", 64'(stall_s), 64'd0);
            chk("mid_rst_ctrl", 64'({fw_s, mreq_s}), 64'd0);
            @(negedge clk);
            req = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 3; c++) begin
                #1;
                if (fw_s) fills++;
                chk("post_rst_idle", 64'({stall_s, mreq_s}) | 64'(ma_s) | fd_s, 64'd0);
                @(negedge clk);
            end
            chk("mid_no_fill", 64'(fills), 64'd0);
            do_access(2'd1, 1'b0, 32'h1236, 8'h00, 1'b0, 0);
            chk("refetch_beats", 64'(o_baddr.size()), 64'd4);
            if (o_baddr.size() > 0) chk("refetch_first", 64'(o_baddr[0]), 64'h1234);
            chk("refetch_fdata", o_fdata, 64'hA3A2A1A0);
        end

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  s = 2'($urandom_range(0, 2));
            logic        w = 1'($urandom_range(0, 1));
            logic        h = 1'($urandom_range(0, 1));
            logic [31:0] a = $urandom;
            logic [7:0]  d = 8'($urandom);
            int          waits = $urandom_range(0, 3);
            do_access(s, w, a, d, h, waits);
            model_check(s, w, a, d, h, waits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Memory-side controller for the byte-addressed baseCache family. It services the cache from the memory end. On a read miss it fetches the whole block from main memory one byte per handshake and writes it into the cache in a single fill cycle. It forwards every CPU write to memory (write-through, no write-allocate) and stalls the CPU until each access retires.

## Interface
Parameters:
- BLOCK_SIZE, 4, bytes per cache block; legal values 1, 2, 4, 8 (matches cache BLOCK_SIZE)
- BLOCK_WIDTH, BLOCK_SIZE*8, fill data width; must equal the cache din width
- OFF_W, log2(BLOCK_SIZE), block offset bits; 0 when BLOCK_SIZE=1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req  in  1  CPU access valid; held with addr/wr/wdata stable while stall=1
- wr  in  1  1 = write, 0 = read
- addr  in  32  CPU byte address
- wdata  in  8  CPU write byte
- hit  in  1  cache hit for current addr, same cycle
- stall  out  1  CPU must hold current access
- fill_wr  out  1  one-cycle cache write strobe for the refilled block
- fill_addr  out  32  block-aligned refill address
- fill_data  out  BLOCK_WIDTH  refilled block; byte k in bits [8k+7:8k]
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = memory write
- mem_addr  out  32  memory byte address
- mem_wdata  out  8  memory write byte
- mem_ack  in  1  memory handshake complete; read data valid same cycle
- mem_rdata  in  8  memory read byte

## Operation
- start = req & (wr | ~hit), evaluated only in IDLE.
- FSM states: IDLE, RD_BEAT, FILL, WR_MEM, DONE.
- IDLE:
  - start & ~wr: latch base = {addr[31:OFF_W], OFF_W'b0}; beat = 0; go to RD_BEAT.
  - start & wr: latch addr and wdata; go to WR_MEM.
  - req & hit & ~wr: no action, no stall.
- RD_BEAT:
  - mem_req=1, mem_we=0, mem_addr = base + beat.
  - On mem_ack, load mem_rdata into buffer byte lane `beat`.
  - After the ack with beat = BLOCK_SIZE-1, go to FILL; on any other ack, increment beat.
  - Addition never carries out of the offset field.
- FILL: fill_wr=1, fill_addr=base, fill_data=buffer; go to DONE unconditionally.
- WR_MEM: mem_req=1, mem_we=1, mem_addr = latched addr, mem_wdata = latched wdata; on mem_ack go to DONE.
- DONE:
  - stall=0; the held CPU access retires this cycle.
  - A read hits because the cache was written in FILL.
  - No start is evaluated here; next state is IDLE.
  - The CPU must present a new access, or deassert req, on the following cycle.
- stall = start (in IDLE) | (state ∈ {RD_BEAT, FILL, WR_MEM}).
- Handshake rules:
  - mem_ack is sampled only while mem_req=1; an ack while mem_req=0 is ignored.
  - mem_addr, mem_we and mem_wdata stay stable from mem_req rise to the ack cycle.
  - A zero-wait ack in the first request cycle is legal.
  - There is no back-to-back beat gap: mem_req stays high across consecutive beats.
- fill_wr, mem_req and mem_we are 0 in all states not listed above.

## Timing
- Reset (async, immediate):
  - State goes to IDLE; beat, base and buffer clear to 0.
  - stall, fill_wr, mem_req and mem_we are forced 0, and all data/address outputs read 0, while rst=1.
- Reset mid-burst or mid-write:
  - mem_req drops within the same cycle and the partial block is discarded.
  - No fill_wr is issued.
  - The memory side must tolerate the abandoned request.
- Read hit: 0 stall cycles.
- Read miss with zero-wait memory:
  - Detect at cycle 0, beats in cycles 1..B, FILL at cycle B+1, DONE at cycle B+2.
  - stall is high for B+2 cycles; B = BLOCK_SIZE.
- Read miss with W wait cycles per beat: stall is high for 2 + B·(W+1) cycles.
- Write (hit or miss), zero-wait: stall is high for 2 cycles (IDLE detect, WR_MEM); DONE at cycle 2. The cache updates its own copy on a write hit.
- fill_wr is exactly one cycle wide per miss.

## Test plan
- Reset behaviour:
  - Stimulus: assert rst mid-sequence with req=1, hit=0.
  - Required: stall=0, mem_req=0 and fill_wr=0 immediately.
  - After release with req=0: state is IDLE and all outputs are 0.
- Read miss, BLOCK_SIZE=4, zero-wait memory:
  - Stimulus: addr=0x0000_1236, memory returns 0xA0,0xA1,0xA2,0xA3.
  - Required: mem_addr sequence 0x1234..0x1237; fill_wr at cycle 5 with fill_addr=0x1234, fill_data=0xA3A2A1A0.
  - Required: stall low at cycle 6.
- Read miss with 2 wait cycles per beat:
  - Required: mem_req held continuously and mem_addr stable within each beat.
  - Required: stall high for exactly 14 cycles.
  - Stimulus: spurious mem_ack pulse while in IDLE → ignored.
- Write-through:
  - Stimulus: wr=1, addr=0x40, wdata=0x5C, hit=1.
  - Required: one memory write with mem_we=1, mem_addr=0x40, mem_wdata=0x5C; no fill_wr; stall high for 2 cycles.
  - Repeat with hit=0: identical memory write, no fill_wr.
- BLOCK_SIZE=1 and BLOCK_SIZE=8 builds:
  - BLOCK_SIZE=1, addr=0x7: single beat at 0x7; fill_data = mem byte.
  - BLOCK_SIZE=8, addr=0xFFFF_FFFB: beats at 0xFFFF_FFF8..0xFFFF_FFFF with no wrap; a 64-bit fill in correct lane order.
- Reset mid-burst:
  - Stimulus: assert rst after beat 2 of 4.
  - Required: no fill_wr is issued.
  - Required: a subsequent miss on the same block refetches all 4 beats starting at offset 0.
